logic_op_arbiter: RTL and testbench

//  Shares one WIDTH-bit bitwise logic unit (AND/OR/NOR/XOR/NAND/XNOR/NOT/PASS)

---
 rtl/logic_op_arbiter.sv | 174 +++++++++++++++++
 tb/tb_logic_op_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// logic_op_arbiter
//   Shares one WIDTH-bit bitwise logic unit between two requesters.
//   Round-robin arbitration picks a requester in IDLE. The accepted op is
//   latched, evaluated in EXEC and returned as a tagged response in RESP.
//   The response is held in RESP until the consumer takes it.
//
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   req0_valid/ready/op/a/b     requester 0 handshake and payload
//   req1_valid/ready/op/a/b     requester 1 handshake and payload
//   rsp_valid/ready/id/data     tagged result handshake
//   busy                        FSM is not in IDLE
//   done_cnt                    completed responses, saturating
// ---------------------------------------------------------------------------
module logic_op_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNTW-1:0]  done_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [1:0]       state_r;
    logic             last_grant_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             id_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic [CNTW-1:0]  done_cnt_r;
    logic             grant0_s;
    logic             grant1_s;

    // Bitwise evaluation of one op; b is unused for NOT a and PASS a.
    function automatic logic [WIDTH-1:0] logic_op_f(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'd0:    res = a & b;
            3'd1:    res = a | b;
            3'd2:    res = ~(a | b);
            3'd3:    res = a ^ b;
            3'd4:    res = ~(a & b);
            3'd5:    res = ~(a ^ b);
            3'd6:    res = ~a;
            3'd7:    res = a;
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Round-robin grant: only in IDLE and out of reset; on contention the
    // requester that did not win last time is chosen.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == ST_IDLE) && rst_n) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Sequencer: latch granted op, evaluate it, hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            op_r         <= 3'd0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            id_r         <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_data_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        op_r         <= grant1_s ? req1_op : req0_op;
                        a_r          <= grant1_s ? req1_a  : req0_a;
                        b_r          <= grant1_s ? req1_b  : req0_b;
                        id_r         <= grant1_s;
                        last_grant_r <= grant1_s;
                        state_r      <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_data_r  <= logic_op_f(op_r, a_r, b_r);
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    // rsp_data/rsp_id deliberately keep their value afterwards.
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Completed-response counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= {CNTW{1'b0}};
        end else if ((state_r == ST_RESP) && rsp_ready && (done_cnt_r != CNT_MAX)) begin
            done_cnt_r <= done_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_data   = rsp_data_r;
    assign busy       = (state_r != ST_IDLE);
    assign done_cnt   = done_cnt_r;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_op_arbiter
//   Directed bench for logic_op_arbiter (WIDTH=4, CNTW=8). Inputs are driven
//   2 time units after each rising edge and outputs sampled at that point.
// ---------------------------------------------------------------------------
module tb_logic_op_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_op;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_op;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_data;
    logic       busy;
    logic [7:0] done_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    logic [3:0] vec_exp [8];

    logic_op_arbiter #(.WIDTH(4), .CNTW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full transaction through requester id with rsp_ready held high.
    task automatic do_op(input logic id, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp);
        int n;
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        #1;
        n = 0;
        while (((id ? req1_ready : req0_ready) !== 1'b1) && (n < 8)) begin
            step();
            n++;
        end
        check_eq("grant", {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("busy_exec", {31'd0, busy}, 32'd1);
        check_eq("ready_exec", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, id});
        check_eq("rsp_data", {28'd0, rsp_data}, {28'd0, exp});
        step();
        if (exp_cnt < 255) exp_cnt++;
        check_eq("rsp_clear", {31'd0, rsp_valid}, 32'd0);
        check_eq("done_cnt", {24'd0, done_cnt}, exp_cnt);
    endtask

    initial begin
        int n;
        vec_exp[0] = 4'b0001; vec_exp[1] = 4'b0111; vec_exp[2] = 4'b1000; vec_exp[3] = 4'b0110;
        vec_exp[4] = 4'b1110; vec_exp[5] = 4'b1001; vec_exp[6] = 4'b1010; vec_exp[7] = 4'b0101;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp_ready = 1'b1;
        step();
        step();
        check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done_cnt", {24'd0, done_cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // NOR cases, including latency to the response.
        do_op(1'b0, 3'd2, 4'b0110, 4'b1001, 4'b0000);
        do_op(1'b0, 3'd2, 4'b0000, 4'b0000, 4'b1111);

        // Reset in the middle of an op: everything zero, op discarded.
        req1_op = 3'd7; req1_a = 4'b1011; req1_b = 4'b0000; req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        step();
        #1;
        rsp_ready = 1'b0;
        req0_op = 3'd0; req0_a = 4'b1100; req0_b = 4'b1010; req0_valid = 1'b1;
        req1_op = 3'd3; req1_a = 4'b1100; req1_b = 4'b1010; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("async_rsp_id", {31'd0, rsp_id}, 32'd0);
        check_eq("async_rsp_data", {28'd0, rsp_data}, 32'd0);
        check_eq("async_busy", {31'd0, busy}, 32'd0);
        check_eq("async_done_cnt", {24'd0, done_cnt}, 32'd0);
        check_eq("async_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        exp_cnt = 0;
        step();
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check_eq("post_reset_grant", {30'd0, req1_ready, req0_ready}, 32'd1);

        // Both requesters valid every cycle: ids alternate starting at 0.
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while ((rsp_valid !== 1'b1) && (n < 8)) begin
                step();
                n++;
            end
            check_eq("rr_id", {31'd0, rsp_id}, (k % 2));
            check_eq("rr_data", {28'd0, rsp_data}, (k % 2 == 0) ? 32'h8 : 32'h6);
            step();
            exp_cnt++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
        step();
        check_eq("rr_done_cnt", {24'd0, done_cnt}, exp_cnt);
        check_eq("rr_idle", {31'd0, busy}, 32'd0);

        // Back-pressure: response held stable while rsp_ready is low.
        rsp_ready = 1'b0;
        req1_op = 3'd1; req1_a = 4'b1100; req1_b = 4'b0011; req1_valid = 1'b1;
        #1;
        check_eq("bp_grant", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_data", {28'd0, rsp_data}, 32'hF);
            check_eq("bp_id", {31'd0, rsp_id}, 32'd1);
            check_eq("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            check_eq("bp_cnt", {24'd0, done_cnt}, exp_cnt);
            step();
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        exp_cnt++;
        check_eq("bp_release_cnt", {24'd0, done_cnt}, exp_cnt);
        check_eq("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("bp_data_kept", {28'd0, rsp_data}, 32'hF);

        // All eight op codes, alternating requesters.
        for (int k = 0; k < 8; k++) begin
            do_op(k[0], k[2:0], 4'b0101, 4'b0011, vec_exp[k]);
        end

        // Saturation: continuous ops from requester 0 after a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_op = 3'd0; req0_a = 4'hF; req0_b = 4'hF; req0_valid = 1'b1;
        for (int k = 0; k < 600; k++) step();
        check_eq("sat_mid", {24'd0, done_cnt}, 32'd200);
        for (int k = 0; k < 200; k++) step();
        check_eq("sat_max", {24'd0, done_cnt}, 32'd255);
        req0_valid = 1'b0;
        step();
        step();
        step();
        check_eq("sat_hold", {24'd0, done_cnt}, 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
